// File: rtl/cycle_sequencer_if.sv
// Handshake bundle between the instruction-cycle sequencer and the core around it.
// The slave side is the sequencer itself; the master side drives run, the ROM word and execute requests.
interface cycle_sequencer_if #(
  parameter int PC_WIDTH = 8
);
  logic                run;
  logic [7:0]          prog_data;
  logic                branch_req;
  logic [PC_WIDTH-1:0] branch_target;
  logic                skip_req;
  logic                clk1;
  logic                clk2;
  logic                clk3;
  logic                clk4;
  logic [PC_WIDTH-1:0] pc;
  logic [7:0]          inst_reg;
  logic                inst_valid;

  modport master (
    output run, prog_data, branch_req, branch_target, skip_req,
    input  clk1, clk2, clk3, clk4, pc, inst_reg, inst_valid
  );

  modport slave (
    input  run, prog_data, branch_req, branch_target, skip_req,
    output clk1, clk2, clk3, clk4, pc, inst_reg, inst_valid
  );
endinterface

// File: rtl/cycle_sequencer.sv
// Four-phase instruction-cycle controller with 2-stage fetch/execute; pc and inst_reg update on the edge leaving Q4.
// Branch/skip cost one NOP bubble cycle; run=0 is honoured only at the end of Q4 so a cycle always completes.
module cycle_sequencer #(
  parameter int         PC_WIDTH = 8,
  parameter logic [7:0] NOP_WORD = 8'h00
) (
  input logic               clk,
  input logic               rst_n,
  cycle_sequencer_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic [3:0]          phase;
  logic [PC_WIDTH-1:0] pc_q;
  logic [7:0]          inst_q;
  logic                valid_q;
  logic                pend_branch;
  logic                pend_skip;
  logic [PC_WIDTH-1:0] pend_tgt;

  assign bus.clk1       = phase[0];
  assign bus.clk2       = phase[1];
  assign bus.clk3       = phase[2];
  assign bus.clk4       = phase[3];
  assign bus.pc         = pc_q;
  assign bus.inst_reg   = inst_q;
  assign bus.inst_valid = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      phase       <= 4'b0000;
      pc_q        <= '0;
      inst_q      <= NOP_WORD;
      valid_q     <= 1'b0;
      pend_branch <= 1'b0;
      pend_skip   <= 1'b0;
      pend_tgt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.run) begin
            state <= RUN;
            phase <= 4'b0001;
          end
        end
        RUN: begin
          if (phase[0]) begin
            phase <= 4'b0010;
          end else if (phase[1]) begin
            phase <= 4'b0100;
          end else if (phase[2]) begin
            phase <= 4'b1000;
            // a bubble in execute must never redirect or skip
            pend_branch <= bus.branch_req & valid_q;
            pend_skip   <= bus.skip_req & valid_q;
            if (valid_q) begin
              pend_tgt <= bus.branch_target;
            end
          end else begin
            if (pend_branch) begin
              pc_q    <= pend_tgt;
              inst_q  <= NOP_WORD;
              valid_q <= 1'b0;
            end else if (pend_skip) begin
              pc_q    <= pc_q + PC_WIDTH'(1);
              inst_q  <= NOP_WORD;
              valid_q <= 1'b0;
            end else begin
              pc_q    <= pc_q + PC_WIDTH'(1);
              inst_q  <= bus.prog_data;
              valid_q <= 1'b1;
            end
            pend_branch <= 1'b0;
            pend_skip   <= 1'b0;
            if (bus.run) begin
              phase <= 4'b0001;
            end else begin
              phase <= 4'b0000;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          phase <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: fetch/execute order, branch/skip bubbles, pc wrap, halt and async reset.
module tb_cycle_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] rom [256];
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  cycle_sequencer_if #(.PC_WIDTH(8)) bus ();

  assign bus.prog_data = rom[bus.pc];

  cycle_sequencer #(.PC_WIDTH(8), .NOP_WORD(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] strobes();
    return {bus.clk4, bus.clk3, bus.clk2, bus.clk1};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    bus.run           = 1'b0;
    bus.branch_req    = 1'b0;
    bus.skip_req      = 1'b0;
    bus.branch_target = 8'h00;
    rst_n             = 1'b0;
    #1;
    check_val({tag, " rst strobes"}, 32'(strobes()), 32'h0);
    check_val({tag, " rst pc"}, 32'(bus.pc), 32'h00);
    check_val({tag, " rst inst"}, 32'(bus.inst_reg), 32'h00);
    check_val({tag, " rst valid"}, 32'(bus.inst_valid), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check_val({tag, " idle strobes"}, 32'(strobes()), 32'h0);
    bus.run = 1'b1;
    step();
  endtask

  // Entered in Q1; leaves the bench in Q1 of the next cycle.
  task automatic run_cycle(input string tag, input logic br, input logic [7:0] tgt, input logic sk,
                           input logic [7:0] exp_inst, input logic exp_vld, input logic [7:0] exp_pc);
    check_val({tag, " q1"}, 32'(strobes()), 32'b0001);
    check_val({tag, " inst"}, 32'(bus.inst_reg), 32'(exp_inst));
    check_val({tag, " valid"}, 32'(bus.inst_valid), 32'(exp_vld));
    step();
    check_val({tag, " q2"}, 32'(strobes()), 32'b0010);
    step();
    check_val({tag, " q3"}, 32'(strobes()), 32'b0100);
    bus.branch_req    = br;
    bus.branch_target = tgt;
    bus.skip_req      = sk;
    step();
    check_val({tag, " q4"}, 32'(strobes()), 32'b1000);
    bus.branch_req = 1'b0;
    bus.skip_req   = 1'b0;
    step();
    check_val({tag, " pc"}, 32'(bus.pc), 32'(exp_pc));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'h5A;
    rom[8'h00] = 8'h11;
    rom[8'h01] = 8'h22;
    rom[8'h02] = 8'h33;
    rom[8'h03] = 8'h44;
    rom[8'h04] = 8'h55;
    rom[8'h40] = 8'hC0;
    rom[8'hFF] = 8'hEE;

    // linear flow with pipeline fill
    do_reset("t1");
    run_cycle("t1 c0", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h01);
    run_cycle("t1 c1", 1'b0, 8'h00, 1'b0, 8'h11, 1'b1, 8'h02);
    run_cycle("t1 c2", 1'b0, 8'h00, 1'b0, 8'h22, 1'b1, 8'h03);
    run_cycle("t1 c3", 1'b0, 8'h00, 1'b0, 8'h33, 1'b1, 8'h04);
    run_cycle("t1 c4", 1'b0, 8'h00, 1'b0, 8'h44, 1'b1, 8'h05);

    // taken branch while executing 22
    do_reset("t2");
    run_cycle("t2 c0", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h01);
    run_cycle("t2 c1", 1'b0, 8'h00, 1'b0, 8'h11, 1'b1, 8'h02);
    run_cycle("t2 c2", 1'b1, 8'h40, 1'b0, 8'h22, 1'b1, 8'h40);
    run_cycle("t2 c3", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h41);
    run_cycle("t2 c4", 1'b0, 8'h00, 1'b0, 8'hC0, 1'b1, 8'h42);

    // skip while executing 11, then branch+skip to FF and wrap
    do_reset("t3");
    run_cycle("t3 c0", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h01);
    run_cycle("t3 c1", 1'b0, 8'h00, 1'b1, 8'h11, 1'b1, 8'h02);
    run_cycle("t3 c2", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h03);
    run_cycle("t3 c3", 1'b0, 8'h00, 1'b0, 8'h33, 1'b1, 8'h04);
    run_cycle("t4 c4", 1'b1, 8'hFF, 1'b1, 8'h44, 1'b1, 8'hFF);
    run_cycle("t4 c5", 1'b1, 8'h10, 1'b1, 8'h00, 1'b0, 8'h00);
    run_cycle("t5 c6", 1'b0, 8'h00, 1'b0, 8'hEE, 1'b1, 8'h01);
    run_cycle("t5 c7", 1'b0, 8'h00, 1'b0, 8'h11, 1'b1, 8'h02);

    // run dropped in Q2: cycle completes, then halt with pc held
    check_val("t6 q1", 32'(strobes()), 32'b0001);
    check_val("t6 inst", 32'(bus.inst_reg), 32'h22);
    step();
    bus.run = 1'b0;
    step();
    check_val("t6 q3", 32'(strobes()), 32'b0100);
    step();
    check_val("t6 q4", 32'(strobes()), 32'b1000);
    step();
    check_val("t6 halt strobes", 32'(strobes()), 32'h0);
    check_val("t6 halt pc", 32'(bus.pc), 32'h03);
    check_val("t6 halt inst", 32'(bus.inst_reg), 32'h33);
    check_val("t6 halt valid", 32'(bus.inst_valid), 32'h1);
    step();
    step();
    step();
    check_val("t6 hold strobes", 32'(strobes()), 32'h0);
    check_val("t6 hold pc", 32'(bus.pc), 32'h03);
    bus.run = 1'b1;
    step();
    check_val("t6 restart q1", 32'(strobes()), 32'b0001);
    check_val("t6 restart inst", 32'(bus.inst_reg), 32'h33);
    step();
    step();
    check_val("t6 pre-rst q3", 32'(strobes()), 32'b0100);

    // async reset in the middle of Q3
    rst_n = 1'b0;
    #1;
    check_val("t6 mid rst strobes", 32'(strobes()), 32'h0);
    check_val("t6 mid rst pc", 32'(bus.pc), 32'h00);
    check_val("t6 mid rst inst", 32'(bus.inst_reg), 32'h00);
    check_val("t6 mid rst valid", 32'(bus.inst_valid), 32'h0);
    step();
    check_val("t6 no q4 strobes", 32'(strobes()), 32'h0);
    check_val("t6 no q4 pc", 32'(bus.pc), 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
